// File: rtl/video_timing_axis.sv
// Single-axis video timing generator: position counter with blank/sync decodes,
// count-enable for cascading and a synchronous restart for raster re-alignment.
module video_timing_axis #(
  parameter int unsigned ACTIVE   = 160,
  parameter int unsigned FRONT    = 4,
  parameter int unsigned SYNC     = 24,
  parameter int unsigned BACK     = 12,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned SCALE_SH = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             advance,
  input  logic             restart,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] coord,
  output logic             blank,
  output logic             sync,
  output logic             done,
  output logic             sync_start
);

  localparam int unsigned TOTAL = ACTIVE + FRONT + SYNC + BACK;

  // Region boundaries at counter width; TOTAL itself may equal 2^CNT_W, so only TOTAL-1 is kept.
  localparam logic [CNT_W-1:0] LAST      = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] BLANK_BEG = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_BEG  = CNT_W'(ACTIVE + FRONT);
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(ACTIVE + FRONT + SYNC - 1);

  logic [CNT_W-1:0] next_count;
  logic             next_blank;
  logic             next_sync;
  logic             next_sync_start;
  logic [CNT_W-1:0] scaled;

  // Out-of-range values (>= TOTAL) fold back to 0 on the next step.
  always_comb begin
    next_count = count;
    if (restart) begin
      next_count = '0;
    end else if (advance) begin
      next_count = (count >= LAST) ? '0 : count + CNT_W'(1);
    end
  end

  // Decode the next count so the registered flags line up with count itself.
  always_comb begin
    next_blank      = (next_count >= BLANK_BEG);
    next_sync       = ((next_count >= SYNC_BEG) && (next_count <= SYNC_LAST)) ? SYNC_POL : ~SYNC_POL;
    next_sync_start = advance & ~restart & (next_count == SYNC_BEG);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count      <= '0;
      blank      <= 1'b0;
      sync       <= ~SYNC_POL;
      sync_start <= 1'b0;
    end else begin
      count      <= next_count;
      blank      <= next_blank;
      sync       <= next_sync;
      sync_start <= next_sync_start;
    end
  end

  assign scaled = count >> SCALE_SH;
  assign coord  = blank ? '0 : scaled;

  // Reflects the current count even when restart wins the same cycle.
  assign done = advance & (count == LAST);

endmodule

// File: tb/tb_video_timing_axis.sv
// Scoreboard bench for video_timing_axis: five instances (default, small, cascaded pair, scaled)
// stepped together, with expected outputs queued per step and compared after each edge.
module tb_video_timing_axis;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_a, advance_a, restart_a;
  logic reset_all, advance_1, restart_0;

  logic [7:0] count_a, coord_a, count_h, coord_h, count_v, coord_v, count_s, coord_s;
  logic [2:0] count_b, coord_b;
  logic blank_a, sync_a, done_a, ss_a;
  logic blank_b, sync_b, done_b, ss_b;
  logic blank_h, sync_h, done_h, ss_h;
  logic blank_v, sync_v, done_v, ss_v;
  logic blank_s, sync_s, done_s, ss_s;

  video_timing_axis u_a (
    .clock(clock), .reset(reset_a), .advance(advance_a), .restart(restart_a),
    .count(count_a), .coord(coord_a), .blank(blank_a), .sync(sync_a),
    .done(done_a), .sync_start(ss_a));

  video_timing_axis #(.ACTIVE(4), .FRONT(1), .SYNC(2), .BACK(1), .SYNC_POL(1'b1), .CNT_W(3)) u_b (
    .clock(clock), .reset(reset_all), .advance(advance_1), .restart(restart_0),
    .count(count_b), .coord(coord_b), .blank(blank_b), .sync(sync_b),
    .done(done_b), .sync_start(ss_b));

  video_timing_axis u_h (
    .clock(clock), .reset(reset_all), .advance(advance_1), .restart(restart_0),
    .count(count_h), .coord(coord_h), .blank(blank_h), .sync(sync_h),
    .done(done_h), .sync_start(ss_h));

  video_timing_axis #(.ACTIVE(120), .FRONT(5), .SYNC(2), .BACK(4)) u_v (
    .clock(clock), .reset(reset_all), .advance(done_h), .restart(restart_0),
    .count(count_v), .coord(coord_v), .blank(blank_v), .sync(sync_v),
    .done(done_v), .sync_start(ss_v));

  video_timing_axis #(.SCALE_SH(1)) u_s (
    .clock(clock), .reset(reset_all), .advance(advance_1), .restart(restart_0),
    .count(count_s), .coord(coord_s), .blank(blank_s), .sync(sync_s),
    .done(done_s), .sync_start(ss_s));

  typedef struct {
    int          id;
    logic [31:0] count;
    logic [31:0] coord;
    logic        blank;
    logic        sync;
    logic        ss;
  } exp_t;

  exp_t  sb[$];
  string nm[5] = '{"A", "B", "H", "V", "S"};
  int    checks = 0;
  int    passes = 0;
  int    cyc = 0;
  int    ma, mb, mh, mv, ms;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Reference position update and region decode written from the timing description.
  function automatic int step(input int cnt, input int total, input bit adv, input bit clr);
    if (clr) return 0;
    if (!adv) return cnt;
    return (cnt >= total - 1) ? 0 : cnt + 1;
  endfunction

  function automatic exp_t expect_of(input int id, input int cnt, input bit ss, input int act,
                                     input int fr, input int sy, input bit pol, input int sh);
    exp_t e;
    e.id    = id;
    e.count = cnt;
    e.blank = (cnt >= act);
    e.sync  = (cnt >= act + fr && cnt < act + fr + sy) ? pol : ~pol;
    e.coord = e.blank ? 0 : (cnt >> sh);
    e.ss    = ss;
    return e;
  endfunction

  function automatic exp_t observe(input int id);
    exp_t o;
    o.id = id;
    case (id)
      0:       begin o.count = count_a; o.coord = coord_a; o.blank = blank_a; o.sync = sync_a; o.ss = ss_a; end
      1:       begin o.count = count_b; o.coord = coord_b; o.blank = blank_b; o.sync = sync_b; o.ss = ss_b; end
      2:       begin o.count = count_h; o.coord = coord_h; o.blank = blank_h; o.sync = sync_h; o.ss = ss_h; end
      3:       begin o.count = count_v; o.coord = coord_v; o.blank = blank_v; o.sync = sync_v; o.ss = ss_v; end
      default: begin o.count = count_s; o.coord = coord_s; o.blank = blank_s; o.sync = sync_s; o.ss = ss_s; end
    endcase
    return o;
  endfunction

  // One clock for all instances; A's controls come from the caller, the rest free-run.
  task automatic tick(input bit adv, input bit rs, input bit rst);
    exp_t e, o;
    int   n;
    bit   vadv;
    advance_a = adv;
    restart_a = rs;
    reset_a   = rst;
    #1;
    vadv = (mh == 199);
    check("A.done", done_a, 32'(adv && ma == 199));
    check("B.done", done_b, 32'(mb == 7));
    check("H.done", done_h, 32'(mh == 199));
    check("V.done", done_v, 32'(vadv && mv == 130));
    n = step(ma, 200, adv, rs || rst);
    sb.push_back(expect_of(0, n, adv && !(rs || rst) && n == 164, 160, 4, 24, 1'b0, 0));
    ma = n;
    n = step(mb, 8, 1'b1, 1'b0);
    sb.push_back(expect_of(1, n, n == 5, 4, 1, 2, 1'b1, 0));
    mb = n;
    n = step(mh, 200, 1'b1, 1'b0);
    sb.push_back(expect_of(2, n, n == 164, 160, 4, 24, 1'b0, 0));
    mh = n;
    n = step(mv, 131, vadv, 1'b0);
    sb.push_back(expect_of(3, n, vadv && n == 125, 120, 5, 2, 1'b0, 0));
    mv = n;
    n = step(ms, 200, 1'b1, 1'b0);
    sb.push_back(expect_of(4, n, n == 164, 160, 4, 24, 1'b0, 1));
    ms = n;
    @(posedge clock);
    #1;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      o = observe(e.id);
      check({nm[e.id], ".count"}, o.count, e.count);
      check({nm[e.id], ".coord"}, o.coord, e.coord);
      check({nm[e.id], ".blank"}, o.blank, e.blank);
      check({nm[e.id], ".sync"}, o.sync, e.sync);
      check({nm[e.id], ".sync_start"}, o.ss, e.ss);
    end
    cyc++;
  endtask

  task automatic run_to(input int target);
    for (int k = 0; k < 400 && count_a != 8'(target); k++) tick(1'b1, 1'b0, 1'b0);
    check("A.reach", count_a, target);
  endtask

  task automatic expect_home(input string tag);
    check({tag, ".count"}, count_a, 0);
    check({tag, ".blank"}, blank_a, 0);
    check({tag, ".sync"}, sync_a, 1);
    check({tag, ".coord"}, coord_a, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d passed=%0d", checks, passes);
    $fatal(1, "watchdog");
  end

  initial begin
    int ss_first = -1;
    int ss_last = -1;
    int ss_seen = 0;
    int frame_edges = -1;
    logic prev_ss;
    logic [7:0] prev_v;

    reset_a = 1'b1; reset_all = 1'b1; advance_a = 1'b1; restart_a = 1'b0;
    advance_1 = 1'b1; restart_0 = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst.A.count", count_a, 0);
    check("rst.A.coord", coord_a, 0);
    check("rst.A.blank", blank_a, 0);
    check("rst.A.sync", sync_a, 1);
    check("rst.A.sync_start", ss_a, 0);
    check("rst.A.done", done_a, 0);
    check("rst.B.sync", sync_b, 0);
    check("rst.V.count", count_v, 0);
    ma = 0; mb = 0; mh = 0; mv = 0; ms = 0;
    reset_all = 1'b0;

    // Free run: 400 cycles, period and scaled coordinate spot checks.
    for (int i = 0; i < 400; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      if (ss_a) begin
        ss_seen++;
        if (ss_first < 0) ss_first = cyc; else ss_last = cyc;
        check("A.ss_at_164", count_a, 164);
      end
      if (count_s == 8'd3)   check("S.coord3", coord_s, 1);
      if (count_s == 8'd159) check("S.coord159", coord_s, 79);
      if (count_s == 8'd180) check("S.coord_blank", coord_s, 0);
    end
    check("A.ss_count", ss_seen, 2);
    check("A.period", ss_last - ss_first, 200);

    // Advance in a 1-in-3 pattern; sync_start must stay a single-cycle pulse.
    prev_ss = 1'b0;
    for (int i = 0; i < 240; i++) begin
      tick(i % 3 == 0, 1'b0, 1'b0);
      check("A.ss_width", ss_a & prev_ss, 0);
      prev_ss = ss_a;
    end

    // Restart and reset while the sync pulse is active.
    run_to(170);
    check("A.sync_active", sync_a, 0);
    tick(1'b1, 1'b1, 1'b0);
    expect_home("restart");
    run_to(190);
    tick(1'b1, 1'b0, 1'b1);
    expect_home("reset");
    run_to(170);
    tick(1'b1, 1'b1, 1'b1);
    expect_home("both");
    run_to(199);
    tick(1'b1, 1'b1, 1'b0);
    expect_home("restart_at_last");
    run_to(5);
    tick(1'b0, 1'b1, 1'b0);
    expect_home("restart_stalled");

    // Keep stepping until the cascaded frame completes.
    while (frame_edges < 0 && cyc < 27000) begin
      prev_v = count_v;
      tick(1'b1, 1'b0, 1'b0);
      if (count_v != prev_v) check("V.step_on_hwrap", count_h, 0);
      if (prev_v == 8'd130 && count_v == 8'd0) frame_edges = cyc;
    end
    check("V.frame_len", frame_edges, 26200);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
